decode_issue_ctrl: RTL and testbench
====================================

Name: decode_issue_ctrl

Overview:
- Decode/issue controller between fetch and execute in the RV32I core.
- Holds one fetched instruction in a decode register and splits it into opcode/rd/funct3/rs1/rs2/funct7 fields.
- Tracks in-flight destination registers in a scoreboard and stalls issue on RAW/WAW hazards until write-back.
- Handles handshakes on both sides, plus pipeline flush and a saturating stall counter.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked (x0 never busy).
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  kill the held instruction (branch/exception redirect)
- if_valid  in  1  fetch offers an instruction
- if_inst  in  32  instruction word
- if_ready  out  1  decode register can accept this cycle
- id_valid  out  1  decoded instruction is issuable
- id_ready  in  1  execute accepts
- id_opcode  out  7  inst[6:0]
- id_rd  out  5  inst[11:7]
- id_funct3  out  3  inst[14:12]
- id_rs1  out  5  inst[19:15]
- id_rs2  out  5  inst[24:20]
- id_funct7  out  7  inst[31:25]
- wb_valid  in  1  write-back retires a register write
- wb_rd  in  5  register being written back
- busy_vec  out  NUM_REGS  current scoreboard
- stall_cnt  out  STALL_CNT_W  cycles with a held instruction blocked by hazard, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Decode register empty; busy_vec=0; stall_cnt=0.
  - if_ready=1 from the first cycle after reset.
  - id_valid=0; all id_* field outputs 0.
- FSM has two states:
  - EMPTY: if_ready=1. if_valid && !flush loads if_inst and goes to HELD.
  - HELD: the field outputs are decoded from the held word.
    - Issue fire is id_valid && id_ready.
    - On fire, with if_valid, load the next word and stay HELD; without if_valid, go to EMPTY.
    - Without fire, stay HELD.
    - if_ready = !held || fire, so back-to-back throughput is 1 instruction/cycle with 1-cycle latency from acceptance to id_valid.
- Register usage, decided by opcode from the shared package:
  - Uses rs1: all opcodes except LUI, AUIPC, JAL.
  - Uses rs2: OP, STORE, BRANCH.
  - Writes rd: all opcodes except STORE, BRANCH, and only when rd != 0.
- Hazard:
  - hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd]).
  - Uses the registered busy_vec only; there is no same-cycle write-back bypass, so a write-back clears the bit and the dependent issues one cycle later.
  - id_valid = held && !hazard && !flush.
- Scoreboard:
  - On fire with writes_rd, set busy[rd] at the clock edge.
  - On wb_valid with wb_rd != 0, clear busy[wb_rd].
  - Set and clear of the same index in one cycle cannot occur, because WAW is stalled. Clear has priority as a defensive rule.
  - wb_valid for a non-busy register is ignored.
  - busy[0] is always 0.
- flush:
  - Has priority over everything else. The next state is EMPTY, and an if_valid in the same cycle is dropped.
  - if_ready stays asserted during flush.
  - id_valid=0 in the flush cycle; no scoreboard set.
  - The scoreboard is untouched, because older in-flight writes still retire.
- stall_cnt increments each cycle with held && hazard && !flush and saturates at all-ones.
- Field outputs:
  - Combinational from the decode register.
  - Hold their value while HELD and not fired.
  - Retain the last value when EMPTY; only id_valid qualifies them.

Decomposition:
- Shared package (existing constants file) holds:
  - Opcode localparams: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM.
  - Typedef dec_state_t {EMPTY, HELD}.
  - Typedef for the decoded-field bundle.
- One sub-module is natural: the existing instruction field decoder, instantiated on the decode register output.
- The scoreboard stays inline.

Test Plan:
- Reset then stream ADD x1,x2,x3 (0x003100B3) followed by ADDI x4,x0,5 with id_ready=1:
  - Both issue on consecutive cycles with fields rd=1, rs1=2, rs2=3, funct7=0.
  - busy_vec=0x12.
- RAW: ADD x5,… issues, then SUB x6,x5,x7 held:
  - id_valid=0 and stall_cnt counts until wb_valid/wb_rd=5.
  - id_valid=1 the cycle after the write-back.
- WAW and x0: LUI x0 never sets busy; two writes to x8 stall the second until wb_rd=8.
- Backpressure: id_ready=0 for 3 cycles:
  - if_ready=0 and fields stable.
  - Releasing id_ready issues the held instruction and accepts the next in the same cycle.
- Flush with if_valid=1 while HELD:
  - The next cycle is EMPTY with id_valid=0.
  - busy_vec is unchanged.
  - The dropped word is never issued.
- Hold hazard for 2^STALL_CNT_W+5 cycles (STALL_CNT_W=4 build): stall_cnt saturates at 15.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode constants: RV32I opcodes, decode FSM states,
// decoded-field bundle and register-usage helpers.
package decode_issue_ctrl_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } dec_fields_t;

  function automatic logic uses_rs1(
    input logic [6:0] op
  );
    return !(op == LUI || op == AUIPC
             || op == JAL);
  endfunction

  function automatic logic uses_rs2(
    input logic [6:0] op
  );
    return op == OP || op == STORE
           || op == BRANCH;
  endfunction

  // rd != 0 is qualified by the caller
  function automatic logic writes_rd(
    input logic [6:0] op
  );
    return !(op == STORE || op == BRANCH);
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_dec.sv
// Instruction field decoder: splits a 32-bit RV32I word
// into its fixed-position fields.
module decode_issue_ctrl_dec
  import decode_issue_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output dec_fields_t fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = inst[6:0];
    fields.rd     = inst[11:7];
    fields.funct3 = inst[14:12];
    fields.rs1    = inst[19:15];
    fields.rs2    = inst[24:20];
    fields.funct7 = inst[31:25];
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode/issue controller: one-entry decode register with a
// busy-register scoreboard that stalls RAW/WAW hazards.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  output logic                   if_ready,
  output logic                   id_valid,
  input  logic                   id_ready,
  output logic [6:0]             id_opcode,
  output logic [4:0]             id_rd,
  output logic [2:0]             id_funct3,
  output logic [4:0]             id_rs1,
  output logic [4:0]             id_rs2,
  output logic [6:0]             id_funct7,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  dec_state_t state_q, state_d;
  logic [31:0]         inst_q;
  dec_fields_t         f;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic held, hazard, fire, load;
  logic rs1_u, rs2_u, rd_w;

  decode_issue_ctrl_dec u_dec (
    .inst   (inst_q),
    .fields (f)
  );

  assign held  = (state_q == HELD);
  assign rs1_u = uses_rs1(f.opcode);
  assign rs2_u = uses_rs2(f.opcode);
  assign rd_w  = writes_rd(f.opcode)
                 && (f.rd != 5'd0);

  // registered scoreboard only: no write-back bypass
  assign hazard = (rs1_u && busy_q[f.rs1])
               || (rs2_u && busy_q[f.rs2])
               || (rd_w  && busy_q[f.rd]);

  assign load = if_valid && if_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:
          if (if_valid) state_d = HELD;
        HELD:
          if (fire && !if_valid) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    id_valid = held && !hazard && !flush;
    fire     = id_valid && id_ready;
    if_ready = !held || fire || flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q <= '0;
    end else if (load) begin
      inst_q <= if_inst;
    end
  end

  // clear wins over set for the same index
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (fire && rd_w && int'(f.rd) == i)
        busy_d[i] = 1'b1;
      if (wb_valid && int'(wb_rd) == i)
        busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (held && hazard && !flush
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign busy_vec  = busy_q;
  assign id_opcode = f.opcode;
  assign id_rd     = f.rd;
  assign id_funct3 = f.funct3;
  assign id_rs1    = f.rs1;
  assign id_rs2    = f.rs2;
  assign id_funct7 = f.funct7;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed streams,
// hazards, backpressure, flush and stall-counter saturation.
module tb_decode_issue_ctrl;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        id_valid;
  logic        id_ready;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [6:0]  id_funct7;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_vec;
  logic [3:0]  stall_cnt;

  int   vecs = 0;
  int   errs = 0;
  exp_t q[$];

  decode_issue_ctrl #(
    .NUM_REGS    (32),
    .STALL_CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_ready  (if_ready),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_opcode (id_opcode),
    .id_rd     (id_rd),
    .id_funct3 (id_funct3),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_funct7 (id_funct7),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .busy_vec  (busy_vec),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [6:0] op, input logic [4:0] rd,
    input logic [2:0] f3, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [6:0] f7
  );
    exp_t e;
    e.op = op; e.rd = rd; e.f3 = f3;
    e.rs1 = rs1; e.rs2 = rs2; e.f7 = f7;
    return e;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // monitor: every issue must match the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && id_valid && id_ready) begin
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_issue: got %0h expected none",
                 {id_funct7, id_rs2, id_rs1,
                  id_funct3, id_rd, id_opcode});
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issue_fields",
            {id_funct7, id_rs2, id_rs1,
             id_funct3, id_rd, id_opcode},
            {e.f7, e.rs2, e.rs1, e.f3, e.rd, e.op});
      end
    end
  end

  task automatic send(
    input logic [31:0] w, input bit push,
    input exp_t e
  );
    int n;
    if (push) q.push_back(e);
    if_valid = 1'b1;
    if_inst  = w;
    n = 0;
    @(negedge clk);
    while (!if_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!if_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r);
    @(posedge clk);
    #1;
    wb_valid = 1'b1;
    wb_rd    = r;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t nil;
    nil = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_inst = '0; id_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_if_ready", 32'(if_ready), 1);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_busy", busy_vec, 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_fields",
        {id_funct7, id_rs2, id_rs1,
         id_funct3, id_rd, id_opcode}, 0);

    // back-to-back ADD x1,x2,x3 ; ADDI x4,x0,5
    @(posedge clk); #1;
    id_ready = 1'b1;
    send(32'h003100B3, 1, mk(7'h33, 1, 0, 2, 3, 0));
    send(32'h00500213, 1, mk(7'h13, 4, 0, 0, 5, 0));
    @(negedge clk);
    chk("b2b_busy_mid", busy_vec, 32'h2);
    @(negedge clk);
    chk("b2b_busy", busy_vec, 32'h12);
    chk("b2b_empty", 32'(id_valid), 0);
    chk("empty_retain_rd", 32'(id_rd), 4);
    wb(1);
    wb(4);

    // RAW: ADD x5,x1,x2 ; SUB x6,x5,x7
    send(32'h002082B3, 1, mk(7'h33, 5, 0, 1, 2, 0));
    send(32'h40728333, 1, mk(7'h33, 6, 0, 5, 7, 7'h20));
    @(negedge clk);
    chk("raw_stall0", 32'(id_valid), 0);
    chk("raw_cnt0", 32'(stall_cnt), 0);
    repeat (3) @(negedge clk);
    chk("raw_stall3", 32'(id_valid), 0);
    chk("raw_cnt3", 32'(stall_cnt), 3);
    wb(5);
    @(negedge clk);
    chk("raw_release", 32'(id_valid), 1);
    chk("raw_cnt5", 32'(stall_cnt), 5);
    @(negedge clk);
    chk("raw_busy", busy_vec, 32'h40);
    wb(6);

    // WAW and x0: LUI x0 ; ADDI x8,1 ; ADDI x8,2
    send(32'h12345037, 1, mk(7'h37, 0, 5, 8, 3, 9));
    send(32'h00100413, 1, mk(7'h13, 8, 0, 0, 1, 0));
    send(32'h00200413, 1, mk(7'h13, 8, 0, 0, 2, 0));
    @(negedge clk);
    chk("waw_stall", 32'(id_valid), 0);
    chk("waw_busy", busy_vec, 32'h100);
    @(negedge clk);
    chk("waw_stall2", 32'(id_valid), 0);
    wb(8);
    @(negedge clk);
    chk("waw_release", 32'(id_valid), 1);
    @(negedge clk);
    chk("waw_busy2", busy_vec, 32'h100);
    wb(8);
    @(negedge clk);
    chk("waw_clear", busy_vec, 0);

    // backpressure: ADD x10,x0,x0 held, ADDI x11,x0,3 waits
    @(posedge clk); #1;
    id_ready = 1'b0;
    send(32'h00000533, 1, mk(7'h33, 10, 0, 0, 0, 0));
    q.push_back(mk(7'h13, 11, 0, 0, 3, 0));
    if_valid = 1'b1;
    if_inst  = 32'h00300593;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_if_ready", 32'(if_ready), 0);
      chk("bp_id_valid", 32'(id_valid), 1);
      chk("bp_rd_stable", 32'(id_rd), 10);
    end
    @(posedge clk); #1;
    id_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(if_ready), 1);
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_busy", busy_vec, 32'hC00);

    // flush while HELD with a new word offered
    @(posedge clk); #1;
    id_ready = 1'b0;
    send(32'h00000633, 0, nil);
    flush    = 1'b1;
    if_valid = 1'b1;
    if_inst  = 32'h00700693;
    @(negedge clk);
    chk("fl_if_ready", 32'(if_ready), 1);
    chk("fl_id_valid", 32'(id_valid), 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("fl_empty", 32'(id_valid), 0);
    chk("fl_busy", busy_vec, 32'hC00);
    repeat (3) begin
      @(negedge clk);
      chk("fl_no_issue", 32'(id_valid), 0);
    end

    // saturation: ADD x14,x10,x0 blocked on x10
    @(posedge clk); #1;
    send(32'h00050733, 1, mk(7'h33, 14, 0, 10, 0, 0));
    repeat (21) @(negedge clk);
    chk("sat_stall", 32'(id_valid), 0);
    chk("sat_cnt", 32'(stall_cnt), 15);
    wb(10);
    @(negedge clk);
    chk("sat_release", 32'(id_valid), 1);
    wb(11);
    wb(14);
    @(negedge clk);
    chk("final_busy", busy_vec, 0);
    wb(3);
    @(negedge clk);
    chk("wb_nonbusy", busy_vec, 0);
    chk("sat_hold", 32'(stall_cnt), 15);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
